dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory between the pipeline's memory stage (core port) and a DMA/loader port. It grants at most one access per cycle, drives the memory's enable/write/byte-enable port, and routes the one-cycle-latency read data back to whichever port issued the read. Arbitration is core-priority with a starvation counter that forces a DMA grant after a bounded wait. The arbiter sits between the memory stage and the data memory array.

## Interface
Parameters:
- AW, 10, word-address width; the memory holds 2^AW 32-bit words.
- MAX_WAIT, 4, maximum consecutive cycles DMA may be denied while requesting; legal range is MAX_WAIT >= 1.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- core_req, dma_req  in  1  access request, level, held until granted.
- core_we, dma_we  in  1  1 = write, 0 = read.
- core_addr, dma_addr  in  32  byte address; bits [1:0] are ignored.
- core_wdata, dma_wdata  in  32  write data, already lane-aligned.
- core_be, dma_be  in  4  byte enables for writes; ignored on reads.
- core_gnt, dma_gnt  out  1  combinational grant, same cycle as the request.
- core_stall  out  1  core_req & ~core_gnt; feeds the pipeline hazard unit.
- core_rvalid, dma_rvalid  out  1  one-cycle pulse; read data valid.
- core_rdata, dma_rdata  out  32  read data; 0 whenever the matching rvalid is 0.
- core_err, dma_err  out  1  one-cycle pulse for an out-of-range access.
- mem_en, mem_we  out  1  memory strobe and write enable.
- mem_addr  out  AW  word address, taken from addr[AW+1:2].
- mem_wdata  out  32  write data to memory.
- mem_be  out  4  byte enables to memory.
- mem_rdata  in  32  memory read data, valid the cycle after an enabled read.

## Operation
- Grant rule, evaluated in cycle N while reset is low:
  - If dma_req and wait_cnt >= MAX_WAIT: DMA is granted.
  - Else if core_req: core is granted.
  - Else if dma_req: DMA is granted.
  - Otherwise no grant.
- Grants are one-hot or zero, and never asserted while reset is high.
- wait_cnt (width clog2(MAX_WAIT+1), saturating):
  - Cleared when dma_gnt is high or dma_req is low.
  - Otherwise incremented each cycle, saturating at MAX_WAIT.
  - After a forced DMA grant the counter is 0, so the core wins the next cycle if it is requesting.
- Range check: an access is out of range when addr[31:AW+2] != 0.
  - An out-of-range request is still granted, but mem_en stays 0, so no memory access occurs.
  - Its err pulses in cycle N+1. For a read, rvalid also pulses with rdata = 0.
- Memory port, in the grant cycle:
  - mem_en = grant & in-range.
  - mem_we = granted we.
  - mem_addr, mem_wdata and mem_be are muxed from the granted port.
  - All mem_* outputs are 0 when there is no grant.
- Writes complete in the grant cycle. No rvalid is returned for writes.
- Response tracking: registered state holds resp_valid, resp_owner (0 = core, 1 = DMA) and resp_err, captured at a read grant or at any out-of-range grant.
  - In cycle N+1, the owner's rvalid = resp_valid for reads.
  - The owner's rdata = resp_err ? 0 : mem_rdata.
- Back-to-back accesses are supported: a new grant in N+1 while the response for N is returned. There are no bubbles and no outstanding-request limit beyond one per cycle.

## Timing
- Request to grant: 0 cycles (combinational).
- Read latency: grant in N, rvalid and rdata in N+1.
- err latency: N+1 for both reads and writes.
- Reset values (cycle after reset high, and combinationally during reset):
  - All gnt, rvalid and err outputs are 0; all rdata outputs are 0.
  - mem_en = 0, mem_we = 0, mem_be = 0.
  - wait_cnt = 0, resp_valid = 0.
- Reset asserted in N+1 after a read grant in N: rvalid is forced to 0 and the response is dropped.
- A request present during reset is neither granted nor performed.
- Simultaneous requests with wait_cnt < MAX_WAIT: the core wins and the DMA counter increments.
- Sustained core_req with dma_req: DMA is granted exactly once every MAX_WAIT+1 cycles.

## Test plan
- **Core read:** core read to 0x0000_0010 with mem word 4 = 0xDEADBEEF → core_gnt in N, core_rvalid = 1 and core_rdata = 0xDEADBEEF in N+1, dma_rdata = 0.
- **Simultaneous requests:** core and DMA both request from cycle 0 with MAX_WAIT = 4 → core granted in cycles 0–3, DMA in cycle 4, core in 5–8, DMA in 9; core_stall = 1 in cycles 4 and 9.
- **DMA byte write:** DMA write to 0x0000_0008, be = 4'b0010, wdata = 0x0000AB00 → mem_en = 1, mem_we = 1, mem_addr = 2, mem_be = 4'b0010; no dma_rvalid.
- **Out-of-range read:** with AW = 10, core reads 0x0000_1000 → core_gnt = 1, mem_en = 0; core_err = 1, core_rvalid = 1, core_rdata = 0 in N+1.
- **Back-to-back reads:** DMA reads word 1 then core reads word 2 in consecutive cycles → dma_rvalid in N+1 and core_rvalid in N+2, each with the correct word and no crossover.
- **Reset mid-read:** read granted in N, reset high in N+1 → core_rvalid = 0 in N+1, all outputs 0, wait_cnt = 0 afterward.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter sharing one single-port data memory between the core
// and a DMA port, with a starvation counter and one-cycle read-response routing.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  input  logic [3:0]    core_be,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [31:0]   dma_addr,
  input  logic [31:0]   dma_wdata,
  input  logic [3:0]    dma_be,
  output logic          core_gnt,
  output logic          dma_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic          dma_rvalid,
  output logic [31:0]   core_rdata,
  output logic [31:0]   dma_rdata,
  output logic          core_err,
  output logic          dma_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0]   wait_cnt_reg;
  logic            resp_valid_reg;
  logic            resp_owner_reg;
  logic            resp_err_reg;
  logic            resp_read_reg;

  logic [1:0][31:0] port_addr;
  logic [1:0]       in_range;
  logic             force_dma;
  logic             gnt_any;
  logic             sel_we;
  logic             sel_in_range;
  logic [AW-1:0]    sel_word;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_be;
  logic             resp_live;
  logic [31:0]      resp_data;
  logic             unused_addr_lsb;

  assign port_addr = {dma_addr, core_addr};

  // Any set bit above the memory's word range makes the access out of range.
  for (genvar gi = 0; gi < 2; gi++) begin : g_range
    assign in_range[gi] = (port_addr[gi][31:AW+2] == '0);
  end

  assign unused_addr_lsb = ^{core_addr[1:0], dma_addr[1:0]};

  assign force_dma  = dma_req & (wait_cnt_reg >= CW'(MAX_WAIT));
  assign dma_gnt    = ~reset & dma_req & (force_dma | ~core_req);
  assign core_gnt   = ~reset & core_req & ~force_dma;
  assign core_stall = core_req & ~core_gnt;
  assign gnt_any    = core_gnt | dma_gnt;

  assign sel_we       = dma_gnt ? dma_we : core_we;
  assign sel_in_range = dma_gnt ? in_range[1] : in_range[0];
  assign sel_word     = dma_gnt ? dma_addr[AW+1:2] : core_addr[AW+1:2];
  assign sel_wdata    = dma_gnt ? dma_wdata : core_wdata;
  assign sel_be       = dma_gnt ? dma_be : core_be;

  assign mem_en    = gnt_any & sel_in_range;
  assign mem_we    = gnt_any & sel_we;
  assign mem_addr  = gnt_any ? sel_word  : '0;
  assign mem_wdata = gnt_any ? sel_wdata : '0;
  assign mem_be    = gnt_any ? sel_be    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg   <= '0;
      resp_valid_reg <= 1'b0;
      resp_owner_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_read_reg  <= 1'b0;
    end else begin
      if (dma_gnt || !dma_req) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg < CW'(MAX_WAIT)) begin
        wait_cnt_reg <= wait_cnt_reg + CW'(1);
      end
      // Writes in range complete silently; everything else owes a response.
      resp_valid_reg <= gnt_any & (~sel_we | ~sel_in_range);
      resp_owner_reg <= dma_gnt;
      resp_err_reg   <= ~sel_in_range;
      resp_read_reg  <= ~sel_we;
    end
  end

  assign resp_live   = resp_valid_reg & ~reset;
  assign resp_data   = resp_err_reg ? 32'h0 : mem_rdata;
  assign core_rvalid = resp_live & resp_read_reg & ~resp_owner_reg;
  assign dma_rvalid  = resp_live & resp_read_reg & resp_owner_reg;
  assign core_err    = resp_live & resp_err_reg & ~resp_owner_reg;
  assign dma_err     = resp_live & resp_err_reg & resp_owner_reg;
  assign core_rdata  = core_rvalid ? resp_data : 32'h0;
  assign dma_rdata   = dma_rvalid  ? resp_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a cycle-level
// reference model of the grant, memory and response rules.
module tb_dmem_arbiter;
  localparam int AW       = 10;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [31:0]   core_addr = '0, core_wdata = '0;
  logic [3:0]    core_be = '0;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0]   dma_addr = '0, dma_wdata = '0;
  logic [3:0]    dma_be = '0;
  logic          core_gnt, dma_gnt, core_stall;
  logic          core_rvalid, dma_rvalid, core_err, dma_err;
  logic [31:0]   core_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_be(dma_be),
    .core_gnt(core_gnt), .dma_gnt(dma_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .dma_rvalid(dma_rvalid),
    .core_rdata(core_rdata), .dma_rdata(dma_rdata),
    .core_err(core_err), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array the DUT drives; loaded from the reference image on the first edge.
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Reference model state: DMA denial streak and the response owed next cycle.
  int          denied = 0;
  bit          p_valid = 0, p_owner = 0, p_read = 0, p_err = 0;
  logic [31:0] p_data = '0;
  bit          last_cg = 0, last_dg = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic [3:0] cbe,
                      input bit dreq, input bit dwe, input logic [31:0] daddr,
                      input logic [31:0] dwd, input logic [3:0] dbe);
    bit          ecg, edg, g, gwe, inr, ecrv, edrv, ecerr, ederr;
    logic [31:0] gaddr, gwd;
    logic [3:0]  gbe;
    int          w;
    @(negedge clk);
    reset = rst;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd; core_be = cbe;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_be = dbe;
    #1;
    ecrv  = !rst && p_valid && p_read && !p_owner;
    edrv  = !rst && p_valid && p_read && p_owner;
    ecerr = !rst && p_valid && p_err && !p_owner;
    ederr = !rst && p_valid && p_err && p_owner;
    edg = !rst && dreq && (denied >= MAX_WAIT || !creq);
    ecg = !rst && creq && !edg;
    g   = ecg || edg;
    gwe   = edg ? dwe : cwe;
    gaddr = edg ? daddr : caddr;
    gwd   = edg ? dwd : cwd;
    gbe   = edg ? dbe : cbe;
    inr = (gaddr >> (AW + 2)) == 0;
    w   = int'((gaddr >> 2) % DEPTH);

    check("core_gnt", 32'(core_gnt), 32'(ecg));
    check("dma_gnt", 32'(dma_gnt), 32'(edg));
    check("core_stall", 32'(core_stall), 32'(creq && !ecg));
    check("mem_en", 32'(mem_en), 32'(g && inr));
    check("mem_we", 32'(mem_we), 32'(g && gwe));
    check("mem_addr", 32'(mem_addr), g ? 32'(w) : 32'h0);
    check("mem_wdata", mem_wdata, g ? gwd : 32'h0);
    check("mem_be", 32'(mem_be), g ? 32'(gbe) : 32'h0);
    check("core_rvalid", 32'(core_rvalid), 32'(ecrv));
    check("dma_rvalid", 32'(dma_rvalid), 32'(edrv));
    check("core_err", 32'(core_err), 32'(ecerr));
    check("dma_err", 32'(dma_err), 32'(ederr));
    check("core_rdata", core_rdata, ecrv ? p_data : 32'h0);
    check("dma_rdata", dma_rdata, edrv ? p_data : 32'h0);

    p_valid = g && (!gwe || !inr);
    p_owner = edg;
    p_read  = !gwe;
    p_err   = !inr;
    p_data  = inr ? ref_mem[w] : 32'h0;
    if (g && inr && gwe)
      for (int b = 0; b < 4; b++)
        if (gbe[b]) ref_mem[w][8*b +: 8] = gwd[8*b +: 8];
    if (rst || !dreq || edg) denied = 0;
    else if (denied < MAX_WAIT) denied++;
    last_cg = ecg;
    last_dg = edg;
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  bit          c_req = 0, c_we = 0, d_req = 0, d_we = 0, rst_r = 0;
  logic [31:0] c_addr = '0, c_wd = '0, d_addr = '0, d_wd = '0;
  logic [3:0]  c_be = '0, d_be = '0;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
    if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;

    // Requests present during reset are neither granted nor performed.
    step(1, 1, 1, 32'h10, 32'h12345678, 4'hF, 1, 0, 32'h20, 32'h0, 4'h0);
    step(1, 1, 1, 32'h10, 32'h12345678, 4'hF, 1, 0, 32'h20, 32'h0, 4'h0);
    idle(0);

    // Core read of word 4.
    step(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(0);
    check("tp_core_read_data", core_rdata, 32'hDEADBEEF);

    // Simultaneous requests: DMA forced in through cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 32'h20, 32'h0, 4'h0, 1, 0, 32'h40, 32'h0, 4'h0);
      check("tp_sim_dma_gnt", 32'(dma_gnt), 32'(i == 4 || i == 9));
    end
    idle(0);

    // DMA byte write into lane 1 of word 2.
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h8, 32'h0000AB00, 4'b0010);
    check("tp_dma_wr_addr", 32'(mem_addr), 32'h2);
    idle(0);

    // Out-of-range core read.
    step(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(0);
    check("tp_oor_err", 32'(core_err), 32'h1);

    // Back-to-back: DMA reads word 1, then core reads word 2.
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h4, 32'h0, 4'h0);
    step(0, 1, 0, 32'h8, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(0);

    // Reset in the cycle after a read grant drops the response.
    step(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(1);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h20, 32'h0, 4'h0, 1, 0, 32'h40, 32'h0, 4'h0);
      check("tp_post_reset_dma_gnt", 32'(dma_gnt), 32'(i == 4));
    end

    // Randomized traffic; a denied request is held unchanged until granted.
    for (int n = 0; n < 600; n++) begin
      if (!c_req || last_cg) begin
        c_req = $urandom_range(0, 99) < 70; c_we = $urandom_range(0, 2) == 0;
        c_addr = rand_addr(); c_wd = $urandom; c_be = 4'($urandom);
      end
      if (!d_req || last_dg) begin
        d_req = $urandom_range(0, 99) < 60; d_we = $urandom_range(0, 2) == 0;
        d_addr = rand_addr(); d_wd = $urandom; d_be = 4'($urandom);
      end
      rst_r = $urandom_range(0, 49) == 0;
      step(rst_r, c_req, c_we, c_addr, c_wd, c_be, d_req, d_we, d_addr, d_wd, d_be);
    end
    idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
